// File: rtl/addsub_pkg.sv
// Shared encodings for the adder/subtractor/comparator sequencing front-end.
package addsub_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_CMP = 2'b10;
    localparam logic [1:0] OP_ACC = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] SAT_POS = 4'h7;
    localparam logic [3:0] SAT_NEG = 4'h8;

    // Bit positions inside the compare vector {0, A>B, A<B, A==B}.
    localparam int EQ = 0;
    localparam int LT = 1;
    localparam int GT = 2;

    // A wrapped result with the sign bit set came from a positive overflow.
    function automatic logic [3:0] sat_value(input logic [3:0] wrapped);
        return wrapped[3] ? SAT_POS : SAT_NEG;
    endfunction

endpackage

// File: rtl/addsub_ctrl.sv
// Sequencer for the 4-bit add/sub/compare unit: handshake in, settle, capture, handshake out.
// Optional saturation of overflowing ADD/SUB/ACC results under `define ADDSUB_CTRL_SAT_EN.
module addsub_ctrl
    import addsub_pkg::*;
#(
    parameter int         EXEC_CYCLES = 1,
    parameter logic [3:0] ACC_INIT    = 4'h0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [1:0] in_op,
    input  logic [3:0] in_a,
    input  logic [3:0] in_b,
    output logic [3:0] au_a,
    output logic [3:0] au_b,
    output logic       au_m,
    output logic       au_c,
    input  logic [3:0] au_out,
    input  logic       au_ov,
    input  logic       au_cout,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_data,
    output logic       out_ov,
    output logic       out_cout,
    output logic [3:0] acc,
    output logic       ovf_sticky,
    input  logic       clr_sticky
);

    state_t     state;
    state_t     next_state;
    logic [3:0] wait_cnt;
    logic [1:0] op;
    logic [3:0] result;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: every output of this block is assigned before the case so no path can infer a latch.
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) next_state = EXEC;
            end
            EXEC: begin
                if (wait_cnt == 4'd0) next_state = RESP;
            end
            RESP: begin
                if (out_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        result = au_out;
`ifdef ADDSUB_CTRL_SAT_EN
        if (au_ov && (op != OP_CMP)) result = sat_value(au_out);
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            au_a       <= 4'h0;
            au_b       <= 4'h0;
            au_m       <= 1'b0;
            au_c       <= 1'b0;
            op         <= OP_ADD;
            wait_cnt   <= 4'd0;
            out_data   <= 4'h0;
            out_ov     <= 1'b0;
            out_cout   <= 1'b0;
            out_valid  <= 1'b0;
            acc        <= ACC_INIT;
            ovf_sticky <= 1'b0;
        end else begin
            // A set at capture later in this block overrides this clear.
            if (clr_sticky) ovf_sticky <= 1'b0;

            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op       <= in_op;
                        wait_cnt <= 4'(EXEC_CYCLES - 1);
                        au_a     <= (in_op == OP_ACC) ? acc : in_a;
                        au_b     <= in_b;
                        au_m     <= (in_op == OP_SUB) || (in_op == OP_CMP);
                        au_c     <= (in_op == OP_CMP);
                    end
                end
                EXEC: begin
                    if (wait_cnt != 4'd0) begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end else begin
                        out_data  <= result;
                        out_ov    <= au_ov;
                        out_cout  <= au_cout;
                        out_valid <= 1'b1;
                        if (op == OP_ACC) acc <= result;
                        if (au_ov && (op != OP_CMP)) ovf_sticky <= 1'b1;
                    end
                end
                RESP: begin
                    if (out_ready) out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
